// File: rtl/tensorcore_pkg.sv
// Shared types and constants for the scalar-core to tensorcore command interface.
package tensorcore_pkg;

    localparam int unsigned CMD_QUEUE_DEPTH = 4;
    localparam int unsigned XLEN            = 32;

    localparam logic [6:0] TC_OPCODE = 7'b0001011;

    typedef enum logic [1:0] {
        TC_RESP_OK      = 2'b00,
        TC_RESP_ILLEGAL = 2'b01,
        TC_RESP_FULL    = 2'b10
    } tc_resp_code_e;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } accelerator_req_t;

    typedef struct packed {
        tc_resp_code_e resp;
    } accelerator_resp_t;

endpackage

// File: rtl/tensorcore_cmd_fifo.sv
// First-word fall-through circular command queue with occupancy count.
module tensorcore_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1),
    parameter type         T     = logic [31:0]
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  T                 data_i,
    input  logic             pop_i,
    output T                 data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Empty reads return zero so the head never shows stale or unknown data.
    always_comb begin
        data_o = '0;
        if (!empty_o) begin
            data_o = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap by compare so any DEPTH >= 2 works.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tensorcore_cmd_frontend.sv
// Accepts core requests, classifies them, queues legal commands and returns one response per accept.
module tensorcore_cmd_frontend
    import tensorcore_pkg::*;
#(
    parameter int unsigned DEPTH = tensorcore_pkg::CMD_QUEUE_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  accelerator_req_t  req_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output accelerator_resp_t resp_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output accelerator_req_t  cmd_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              idle_o
);

    typedef enum logic [0:0] {
        RSP_IDLE = 1'b0,
        RSP_PEND = 1'b1
    } rsp_state_e;

    rsp_state_e        state_q;
    logic              resp_valid_q;
    accelerator_resp_t resp_q;

    logic          accept;
    logic          legal;
    logic          pop;
    logic          push;
    logic          space;
    logic          full;
    logic          empty;
    tc_resp_code_e code_c;

    assign req_ready_o = !resp_valid_q || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign legal       = (req_i.instruction[6:0] == TC_OPCODE);
    assign pop         = cmd_valid_o && cmd_ready_i;
    // A full queue still has room when its head leaves on the same edge.
    assign space       = !full || pop;
    assign push        = accept && legal && space;

    always_comb begin
        code_c = TC_RESP_OK;
        if (!legal) begin
            code_c = TC_RESP_ILLEGAL;
        end else if (!space) begin
            code_c = TC_RESP_FULL;
        end
    end

    tensorcore_cmd_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .T     (accelerator_req_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (req_i),
        .pop_i   (pop),
        .data_o  (cmd_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    assign cmd_valid_o  = !empty;
    assign resp_valid_o = resp_valid_q;
    assign resp_o       = resp_q;
    assign idle_o       = empty && !resp_valid_q;

    // Single response slot; a new accept while draining reloads the code with no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RSP_IDLE;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            case (state_q)
                RSP_IDLE: begin
                    if (accept) begin
                        state_q      <= RSP_PEND;
                        resp_valid_q <= 1'b1;
                        resp_q.resp  <= code_c;
                    end
                end
                RSP_PEND: begin
                    if (resp_ready_i) begin
                        if (accept) begin
                            resp_q.resp <= code_c;
                        end else begin
                            state_q      <= RSP_IDLE;
                            resp_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= RSP_IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tensorcore_cmd_frontend.sv
// Table-driven and randomized checks of the tensorcore command frontend against a queue-based model.
module tb_tensorcore_cmd_frontend;
    import tensorcore_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    accelerator_req_t  req_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    accelerator_resp_t resp_o;
    logic              cmd_valid_o;
    logic              cmd_ready_i;
    accelerator_req_t  cmd_o;
    logic [CNT_W-1:0]  count_o;
    logic              idle_o;

    tensorcore_cmd_frontend #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_i        (req_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_o       (resp_o),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_ready_i  (cmd_ready_i),
        .cmd_o        (cmd_o),
        .count_o      (count_o),
        .idle_o       (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the queue contents plus the one outstanding response.
    accelerator_req_t m_q[$];
    logic             m_pend;
    logic [1:0]       m_code;
    logic [31:0]      pop_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic accelerator_req_t mk(input logic legal, input logic [31:0] rs1, input logic [31:0] rs2);
        accelerator_req_t r;
        r.instruction = $urandom;
        if (legal) r.instruction[6:0] = TC_OPCODE;
        else if (r.instruction[6:0] == TC_OPCODE) r.instruction[6:0] = 7'h33;
        r.rs1 = rs1;
        r.rs2 = rs2;
        return r;
    endfunction

    // One clock: drive inputs, check comb ready, advance model, check registered state.
    task automatic cycle(input logic v, input accelerator_req_t r, input logic rr, input logic cr,
                         input logic rst, output logic acc, output logic [1:0] code);
        logic rdy;
        logic pop;
        logic psh;
        req_valid_i  = v;
        req_i        = r;
        resp_ready_i = rr;
        cmd_ready_i  = cr;
        rst_i        = rst;
        #1;
        rdy = !m_pend || rr;
        chk("req_ready", 128'(req_ready_o), 128'(rdy));
        if (cmd_valid_o && cr && !rst) pop_log.push_back(cmd_o.rs1);
        acc  = v && rdy && !rst;
        code = TC_RESP_OK;
        pop  = (m_q.size() > 0) && cr;
        psh  = 1'b0;
        if (acc) begin
            if (r.instruction[6:0] != TC_OPCODE) code = TC_RESP_ILLEGAL;
            else if (m_q.size() < DEPTH || pop) psh = 1'b1;
            else code = TC_RESP_FULL;
        end
        @(posedge clk_i);
        if (rst) begin
            m_q.delete();
            m_pend = 1'b0;
            m_code = TC_RESP_OK;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (psh) m_q.push_back(r);
            if (acc) begin
                m_pend = 1'b1;
                m_code = code;
            end else if (rr) begin
                m_pend = 1'b0;
            end
        end
        #1;
        chk("resp_valid", 128'(resp_valid_o), 128'(m_pend));
        if (m_pend) chk("resp_code", 128'(resp_o), 128'(m_code));
        chk("count", 128'(count_o), 128'(m_q.size()));
        chk("cmd_valid", 128'(cmd_valid_o), 128'(m_q.size() > 0));
        if (m_q.size() > 0) chk("cmd_head", 128'(cmd_o), 128'(m_q[0]));
        chk("idle", 128'(idle_o), 128'(m_q.size() == 0 && !m_pend));
    endtask

    task automatic do_reset();
        logic a;
        logic [1:0] c;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, a, c);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic        legal;
        logic [31:0] rs1;
        logic        cr;
        logic [1:0]  exp_resp;
        int          exp_count;
        logic [31:0] exp_head;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic a;
        logic [1:0] c;
        accelerator_req_t r;
        accelerator_resp_t held;
        int sent;
        int cyc;

        m_pend = 1'b0;
        m_code = TC_RESP_OK;
        req_valid_i = 1'b0; req_i = '0; resp_ready_i = 1'b1; cmd_ready_i = 1'b0; rst_i = 1'b1;

        // Single legal, illegal, fill to full, full drop, full-with-pop.
        tbl[0] = '{1'b1,  1, 1'b0, TC_RESP_OK,      1,  1};
        tbl[1] = '{1'b0, 99, 1'b0, TC_RESP_ILLEGAL, 1,  1};
        tbl[2] = '{1'b1, 10, 1'b0, TC_RESP_OK,      2,  1};
        tbl[3] = '{1'b1, 11, 1'b0, TC_RESP_OK,      3,  1};
        tbl[4] = '{1'b1, 12, 1'b0, TC_RESP_OK,      4,  1};
        tbl[5] = '{1'b1, 13, 1'b0, TC_RESP_FULL,    4,  1};
        tbl[6] = '{1'b1, 14, 1'b1, TC_RESP_OK,      4, 10};

        do_reset();
        chk("rst_resp", 128'(resp_o), 128'(2'b00));
        chk("rst_cmd_not_x", 128'($isunknown(cmd_o)), 128'(0));
        for (int i = 0; i < 7; i++) begin
            r = mk(tbl[i].legal, tbl[i].rs1, 32'(i + 2));
            if (i == 0) r.instruction = 32'h0000000B;
            if (i == 1) r.instruction = 32'h00000033;
            cycle(1'b1, r, 1'b1, tbl[i].cr, 1'b0, a, c);
            chk($sformatf("tbl%0d_resp", i), 128'(resp_o), 128'(tbl[i].exp_resp));
            chk($sformatf("tbl%0d_count", i), 128'(count_o), 128'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_head", i), 128'(cmd_o.rs1), 128'(tbl[i].exp_head));
        end

        // Response backpressure holds the code and blocks new requests.
        do_reset();
        cycle(1'b1, mk(1'b1, 7, 0), 1'b0, 1'b0, 1'b0, a, c);
        held = resp_o;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, mk(1'b0, 8, 0), 1'b0, 1'b0, 1'b0, a, c);
            chk("bp_ready_low", 128'(req_ready_o), 128'(0));
            chk("bp_resp_stable", 128'(resp_o), 128'(held));
        end
        cycle(1'b1, mk(1'b0, 8, 0), 1'b1, 1'b0, 1'b0, a, c);
        chk("bp_b2b_valid", 128'(resp_valid_o), 128'(1));
        chk("bp_b2b_code", 128'(resp_o), 128'(TC_RESP_ILLEGAL));

        // Ordering and pointer wrap with random backpressure on both sides.
        do_reset();
        pop_log.delete();
        sent = 0;
        cyc  = 0;
        while (sent < 20 && cyc < 2000) begin
            cycle(1'b1, mk(1'b1, 32'(sent), $urandom), 1'($urandom), 1'($urandom), 1'b0, a, c);
            if (a && c == TC_RESP_OK) sent++;
            cyc++;
        end
        chk("order_send_timeout", 128'(sent), 128'(20));
        cyc = 0;
        while (m_q.size() > 0 && cyc < 100) begin
            cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, a, c);
            cyc++;
        end
        chk("order_pop_count", 128'(pop_log.size()), 128'(20));
        for (int i = 0; i < 20 && i < pop_log.size(); i++) begin
            chk($sformatf("order_rs1_%0d", i), 128'(pop_log[i]), 128'(i));
        end

        // Reset mid-operation with three queued commands and a pending response.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(1'b1, 32'(40 + i), 0), 1'b0, 1'b0, 1'b0, a, c);
        for (int i = 0; i < 2; i++) cycle(1'b1, mk(1'b1, 32'(40 + i), 0), 1'b1, 1'b0, 1'b0, a, c);
        chk("pre_rst_count", 128'(count_o), 128'(3));
        cycle(1'b1, mk(1'b1, 50, 0), 1'b0, 1'b0, 1'b1, a, c);
        rst_i = 1'b0;
        chk("mid_rst_valid", 128'(resp_valid_o), 128'(0));
        chk("mid_rst_resp", 128'(resp_o), 128'(2'b00));
        chk("mid_rst_cmd_valid", 128'(cmd_valid_o), 128'(0));
        chk("mid_rst_count", 128'(count_o), 128'(0));
        chk("mid_rst_idle", 128'(idle_o), 128'(1));
        chk("mid_rst_ready", 128'(req_ready_o), 128'(1));
        cycle(1'b1, mk(1'b1, 60, 0), 1'b1, 1'b0, 1'b0, a, c);
        chk("post_rst_resp", 128'(resp_o), 128'(TC_RESP_OK));
        chk("post_rst_count", 128'(count_o), 128'(1));

        // Random traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), mk($urandom_range(0, 3) != 0, $urandom, $urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 60) == 0, a, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
